// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V fetch slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

    // Default geometry; riscv_fetch exposes these as overridable parameters.
    localparam int PC_WIDTH   = 15;
    localparam int INST_WIDTH = 32;
    localparam int RESET_PC   = 0;
    localparam int FQ_DEPTH   = 4;

    // Canonical NOP (addi x0, x0, 0), available to decode-side consumers.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Fetch control state: RUN fetches sequentially, HALT parks after a
    // misaligned redirect until the next redirect or reset.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    // A byte address is word-aligned when its two low bits are clear.
    function automatic logic is_word_aligned(input logic [1:0] lo_bits);
        return (lo_bits == 2'b00);
    endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Synchronous fetch queue holding {pc, inst} entries between imem and decode.
// Latency: an entry pushed at edge N is visible at dout after N (head is combinational).
// Backpressure: push is ignored when full unless a pop happens in the same cycle; flush wins over both.
//
// Ports: clk, reset (sync active-low), push/pop/flush controls, din/dout entry,
//        count (entries held), full, empty.
module riscv_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 47,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [DW-1:0]    din,
    output logic [DW-1:0]    dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    import riscv_pkg::*;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Guard against overflow/underflow locally so a careless caller cannot
    // corrupt the pointers; a full queue still accepts a push paired with a pop.
    assign push_ok = push & (~full | pop) & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while count > 0.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/riscv_fetch.sv
// Instruction-fetch stage: owns the PC, drives imem, queues {pc, inst} for decode.
// Latency: first valid 1 cycle after reset release; redirect target visible 2 edges after the redirect.
// Backpressure: id_ready low fills the queue, then imem_pc holds until a pop frees a slot.
//
// Ports: clk, reset (sync active-low); redirect_valid/redirect_pc from execute;
//        imem_pc out / imem_inst in to instruction memory; if_valid/if_inst/if_pc
//        to decode with id_ready back; misalign_err pulses after a misaligned redirect.
module riscv_fetch #(
    parameter int PC_WIDTH   = riscv_pkg::PC_WIDTH,
    parameter int INST_WIDTH = riscv_pkg::INST_WIDTH,
    parameter int RESET_PC   = riscv_pkg::RESET_PC,
    parameter int FQ_DEPTH   = riscv_pkg::FQ_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [PC_WIDTH-1:0]   imem_pc,
    input  logic [INST_WIDTH-1:0] imem_inst,
    output logic                  if_valid,
    output logic [INST_WIDTH-1:0] if_inst,
    output logic [PC_WIDTH-1:0]   if_pc,
    input  logic                  id_ready,
    output logic                  misalign_err
);
    import riscv_pkg::*;

    localparam int ENTRY_W = PC_WIDTH + INST_WIDTH;
    localparam int CNT_W   = $clog2(FQ_DEPTH) + 1;

    fetch_state_t          state_q, state_d;
    logic [PC_WIDTH-1:0]   imem_pc_q, imem_pc_d;
    logic                  misalign_q, misalign_d;

    logic                  fq_push;
    logic                  fq_pop;
    logic                  fq_flush;
    logic                  fq_full;
    logic                  fq_empty;
    logic [CNT_W-1:0]      fq_count;
    logic [ENTRY_W-1:0]    fq_din;
    logic [ENTRY_W-1:0]    fq_dout;
    logic [PC_WIDTH-1:0]   head_pc;
    logic [INST_WIDTH-1:0] head_inst;

    riscv_fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .DW    (ENTRY_W)
    ) u_fq (
        .clk   (clk),
        .reset (reset),
        .push  (fq_push),
        .pop   (fq_pop),
        .flush (fq_flush),
        .din   (fq_din),
        .dout  (fq_dout),
        .count (fq_count),
        .full  (fq_full),
        .empty (fq_empty)
    );

    assign head_pc   = fq_dout[ENTRY_W-1:INST_WIDTH];
    assign head_inst = fq_dout[INST_WIDTH-1:0];

    // Head is presented combinationally; forced to zero when the queue is
    // empty so stale storage never leaks to decode.
    assign if_valid = (fq_count != '0);
    assign if_pc    = fq_empty ? '0 : head_pc;
    assign if_inst  = fq_empty ? '0 : head_inst;

    assign imem_pc      = imem_pc_q;
    assign misalign_err = misalign_q;

    // A redirect voids the pop and the push of its cycle: the head decode sees
    // that cycle belongs to the wrong path, and so does the imem word.
    assign fq_flush = redirect_valid;
    assign fq_pop   = if_valid & id_ready & ~redirect_valid;
    assign fq_push  = (state_q == ST_RUN) & ~redirect_valid & (~fq_full | fq_pop);
    assign fq_din   = {imem_pc_q, imem_inst};

    always_comb begin
        state_d    = state_q;
        imem_pc_d  = imem_pc_q;
        misalign_d = 1'b0;
        if (redirect_valid) begin
            if (is_word_aligned(redirect_pc[1:0])) begin
                imem_pc_d = redirect_pc;
                state_d   = ST_RUN;
            end else begin
                // Park on the aligned-down target so imem_pc stays word-aligned.
                imem_pc_d  = {redirect_pc[PC_WIDTH-1:2], 2'b00};
                misalign_d = 1'b1;
                state_d    = ST_HALT;
            end
        end else if (fq_push) begin
            // Wraps modulo 2^PC_WIDTH by construction.
            imem_pc_d = imem_pc_q + PC_WIDTH'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            imem_pc_q  <= PC_WIDTH'(RESET_PC);
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            imem_pc_q  <= imem_pc_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_riscv_fetch.sv
module tb_riscv_fetch;

    localparam int PW = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          redirect_valid;
    logic [PW-1:0] redirect_pc;
    logic [PW-1:0] imem_pc;
    logic [31:0]   imem_inst;
    logic          if_valid;
    logic [31:0]   if_inst;
    logic [PW-1:0] if_pc;
    logic          id_ready;
    logic          misalign_err;

    always #5 clk = ~clk;

    // Instruction memory model: word encodes its own address.
    assign imem_inst = 32'h1000_0000 | {17'b0, imem_pc};

    riscv_fetch #(
        .PC_WIDTH   (15),
        .INST_WIDTH (32),
        .RESET_PC   (0),
        .FQ_DEPTH   (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .misalign_err   (misalign_err)
    );

    typedef struct {
        logic          rst_n;
        logic          redir;
        logic [PW-1:0] rpc;
        logic          rdy;
        logic          e_vld;
        logic [PW-1:0] e_pc;
        logic [PW-1:0] e_imem;
        logic          e_err;
    } vec_t;

    vec_t          vecs[$];
    logic [PW-1:0] sb_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    bit            mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst_n, input logic redir, input logic [PW-1:0] rpc,
                                input logic rdy, input logic e_vld, input logic [PW-1:0] e_pc,
                                input logic [PW-1:0] e_imem, input logic e_err);
        vec_t v;
        v.rst_n = rst_n; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.e_vld = e_vld; v.e_pc = e_pc; v.e_imem = e_imem; v.e_err = e_err;
        return v;
    endfunction

    // Expected consumption stream after a (re)start: start, start+4, ... wrapping.
    task automatic sb_load(input logic [PW-1:0] start);
        logic [PW-1:0] p;
        sb_q.delete();
        p = start;
        for (int i = 0; i < 16; i++) begin
            sb_q.push_back(p);
            p = p + PW'(4);
        end
    endtask

    // Scoreboard monitor: every accepted head must be the next expected pc.
    always @(negedge clk) begin
        if (mon_en && reset && !redirect_valid && if_valid && id_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: consumed pc %h, expected none", if_pc);
            end else begin
                logic [PW-1:0] e;
                e = sb_q.pop_front();
                check("sb_pc", {17'b0, if_pc}, {17'b0, e});
                check("sb_inst", if_inst, 32'h1000_0000 | {17'b0, e});
            end
        end
    end

    initial begin
        int lat;
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;

        //          rst redir rpc       rdy  vld pc        imem      err
        vecs.push_back(mk(0, 0, 15'h0000, 1, 0, 15'h0000, 15'h0000, 0)); // reset state
        vecs.push_back(mk(1, 0, 15'h0000, 1, 0, 15'h0000, 15'h0000, 0)); // release
        vecs.push_back(mk(1, 0, 15'h0000, 1, 1, 15'h0000, 15'h0004, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 1, 1, 15'h0004, 15'h0008, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 1, 1, 15'h0008, 15'h000C, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 0, 1, 15'h000C, 15'h0010, 0)); // backpressure
        vecs.push_back(mk(1, 0, 15'h0000, 0, 1, 15'h000C, 15'h0014, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 0, 1, 15'h000C, 15'h0018, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 0, 1, 15'h000C, 15'h001C, 0)); // full, holds
        vecs.push_back(mk(1, 0, 15'h0000, 0, 1, 15'h000C, 15'h001C, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 0, 1, 15'h000C, 15'h001C, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 1, 1, 15'h000C, 15'h001C, 0)); // drain while full
        vecs.push_back(mk(1, 0, 15'h0000, 1, 1, 15'h0010, 15'h0020, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 1, 1, 15'h0014, 15'h0024, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 1, 1, 15'h0018, 15'h0028, 0));
        vecs.push_back(mk(1, 1, 15'h0200, 1, 1, 15'h001C, 15'h002C, 0)); // redirect, full
        vecs.push_back(mk(1, 0, 15'h0000, 1, 0, 15'h0000, 15'h0200, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 1, 1, 15'h0200, 15'h0204, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 1, 1, 15'h0204, 15'h0208, 0));
        vecs.push_back(mk(1, 1, 15'h0102, 1, 1, 15'h0208, 15'h020C, 0)); // misaligned
        vecs.push_back(mk(1, 0, 15'h0000, 1, 0, 15'h0000, 15'h0100, 1));
        vecs.push_back(mk(1, 0, 15'h0000, 1, 0, 15'h0000, 15'h0100, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 1, 0, 15'h0000, 15'h0100, 0));
        vecs.push_back(mk(1, 1, 15'h0040, 1, 0, 15'h0000, 15'h0100, 0)); // resume
        vecs.push_back(mk(1, 0, 15'h0000, 1, 0, 15'h0000, 15'h0040, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 1, 1, 15'h0040, 15'h0044, 0));
        vecs.push_back(mk(1, 1, 15'h7FF8, 1, 1, 15'h0044, 15'h0048, 0)); // wrap
        vecs.push_back(mk(1, 0, 15'h0000, 1, 0, 15'h0000, 15'h7FF8, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 1, 1, 15'h7FF8, 15'h7FFC, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 1, 1, 15'h7FFC, 15'h0000, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 1, 1, 15'h0000, 15'h0004, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 1, 1, 15'h0004, 15'h0008, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 0, 1, 15'h0008, 15'h000C, 0)); // build count=3
        vecs.push_back(mk(1, 0, 15'h0000, 0, 1, 15'h0008, 15'h0010, 0));
        vecs.push_back(mk(0, 0, 15'h0000, 0, 1, 15'h0008, 15'h0014, 0)); // reset mid-stream
        vecs.push_back(mk(1, 0, 15'h0000, 1, 0, 15'h0000, 15'h0000, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 1, 1, 15'h0000, 15'h0004, 0));
        vecs.push_back(mk(1, 0, 15'h0000, 1, 1, 15'h0004, 15'h0008, 0));

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            if (!v.rst_n) sb_load('0);
            else if (v.redir) begin
                if (v.rpc[1:0] == 2'b00) sb_load(v.rpc);
                else sb_q.delete();
            end
            reset = v.rst_n; redirect_valid = v.redir; redirect_pc = v.rpc; id_ready = v.rdy;
            @(negedge clk);
            check($sformatf("v%0d_valid", i), {31'b0, if_valid}, {31'b0, v.e_vld});
            check($sformatf("v%0d_if_pc", i), {17'b0, if_pc}, v.e_vld ? {17'b0, v.e_pc} : 32'h0);
            check($sformatf("v%0d_if_inst", i), if_inst,
                  v.e_vld ? (32'h1000_0000 | {17'b0, v.e_pc}) : 32'h0);
            check($sformatf("v%0d_imem_pc", i), {17'b0, imem_pc}, {17'b0, v.e_imem});
            check($sformatf("v%0d_err", i), {31'b0, misalign_err}, {31'b0, v.e_err});
            @(posedge clk);
            #1;
        end

        // Misaligned redirect parks in HALT; reset alone must restart fetch.
        sb_q.delete();
        redirect_valid = 1'b1; redirect_pc = 15'h0106; id_ready = 1'b1;
        @(posedge clk); #1;
        redirect_valid = 1'b0; redirect_pc = '0;
        @(negedge clk);
        check("halt_err", {31'b0, misalign_err}, 32'h1);
        check("halt_valid", {31'b0, if_valid}, 32'h0);
        check("halt_imem_pc", {17'b0, imem_pc}, 32'h0104);
        repeat (2) @(posedge clk);
        #1;
        check("halt_hold_pc", {17'b0, imem_pc}, 32'h0104);
        sb_load('0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        lat = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (if_valid) begin
                lat = k;
                break;
            end
        end
        check("halt_reset_latency", lat, 1);
        repeat (4) @(posedge clk);
        #1;
        id_ready = 1'b0;
        @(negedge clk);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
